ntt_pass_sequencer: RTL and testbench
=====================================

NTT_PASS_SEQUENCER -- requirements
Module: ntt_pass_sequencer

Interface
REQ-001 SHALL have parameter LOG_N, default 16: log2 of the maximum ring dimension.
REQ-002 SHALL have parameter LOG_E, default 3: butterfly stages per NTT pass (log2 lanes).
REQ-003 SHALL have parameter FSIZE, default 64: modulus width.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1: job request.
REQ-007 SHALL have port req_ready  output  1: job accepted when req_valid&req_ready.
REQ-008 SHALL have port req_p  input  FSIZE: job modulus.
REQ-009 SHALL have port req_diff_logN  input  LOG_E: log2 ring-size reduction.
REQ-010 SHALL have port job_done  output  1: one-cycle pulse on job completion.
REQ-011 SHALL have port job_err  output  1: one-cycle pulse on rejected request.
REQ-012 SHALL have port start_NTT  output  1: one-cycle pass-start pulse to the NTT controller.
REQ-013 SHALL have port p  output  FSIZE: modulus to the NTT controller.
REQ-014 SHALL have port NTT_levels  output  LOG_E: active stages in the current pass.
REQ-015 SHALL have port NTT_base_level  output  LOG_N: first NTT level of the current pass.
REQ-016 SHALL have port diff_logN  output  LOG_E: ring reduction to the NTT controller.
REQ-017 SHALL have port NTT_working  input  1: NTT controller busy.
REQ-018 SHALL have port pass_idx  output  LOG_N: index of the current pass, 0-based.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT_RISE, WAIT_FALL, NEXT.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 On accept, the block SHALL latch p and diff_logN, compute L = LOG_N - diff_logN, passes P = ceil(L/LOG_E), and first-pass levels F = L - LOG_E*(P-1).
REQ-022 On accept, the block SHALL set NTT_levels=F, NTT_base_level=0, pass_idx=0, and go to ISSUE.
REQ-023 If req_diff_logN >= LOG_N on accept: no start, job_err pulse next cycle, stay in IDLE.
REQ-024 ISSUE SHALL assert start_NTT for exactly one cycle only when NTT_working==0, then go to WAIT_RISE; while NTT_working==1 it SHALL wait.
REQ-025 WAIT_RISE SHALL go to WAIT_FALL on the first cycle NTT_working==1.
REQ-026 WAIT_FALL SHALL go to NEXT on the first cycle NTT_working==0.
REQ-027 NEXT with pass_idx==P-1 SHALL pulse job_done for one cycle and go to IDLE.
REQ-028 Otherwise NEXT SHALL set NTT_base_level += NTT_levels, NTT_levels=LOG_E, pass_idx+=1, and go to ISSUE.
REQ-029 p, diff_logN, NTT_levels and NTT_base_level SHALL be registered and stable from start_NTT until the pass leaves WAIT_FALL.
REQ-030 req_valid in non-IDLE states SHALL be ignored, not queued.
REQ-031 job_done and job_err SHALL never be asserted in the same cycle.

Reset
REQ-032 rst asserted at any time, including mid-pass, SHALL immediately force state IDLE and zero all outputs except req_ready, which SHALL be 1.
REQ-033 After rst deassert, the block SHALL accept a request on the first clock edge.

Configuration
REQ-034 With macro NTT_SEQ_PERF_EN defined: output busy_cycles [31:0] SHALL count cycles spent outside IDLE for the last job, cleared on accept, saturating at 2^32-1, held after job_done, and reset to 0.
REQ-035 Without NTT_SEQ_PERF_EN: busy_cycles SHALL NOT exist and behaviour SHALL otherwise be identical.

Verification
REQ-036 diff=0, default parameters -> 6 passes with (levels,base) = (1,0),(3,1),(3,4),(3,7),(3,10),(3,13), then one job_done.
REQ-037 diff=1 -> 5 passes, levels 3, bases 0,3,6,9,12; diff=2 -> (2,0),(3,2),(3,5),(3,8),(3,11).
REQ-038 NTT_working held high 10 cycles before ISSUE -> start_NTT delayed until the cycle after it falls, exactly one pulse per pass.
REQ-039 diff=16 with LOG_N=16 and LOG_E=5 -> job_err pulse, start_NTT stays 0, req_ready returns to 1.
REQ-040 rst asserted during the pass-3 WAIT_FALL -> outputs zero in the same cycle; a new request with diff=0 then restarts at pass 0, base 0.
REQ-041 NTT_SEQ_PERF_EN, diff=0, each pass busy 20 cycles -> busy_cycles equals the total non-IDLE cycles and is held after job_done.

Source files
------------

// File: rtl/ntt_pass_sequencer.sv
// Splits one NTT job into LOG_E-stage passes and hands each to the NTT controller.
// Optional busy-cycle counter enabled by defining NTT_SEQ_PERF_EN.
module ntt_pass_sequencer #(
   parameter int LOG_N = 16,
   parameter int LOG_E = 3,
   parameter int FSIZE = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [FSIZE-1:0] req_p,
   input  logic [LOG_E-1:0] req_diff_logN,
   output logic             job_done,
   output logic             job_err,
   output logic             start_NTT,
   output logic [FSIZE-1:0] p,
   output logic [LOG_E-1:0] NTT_levels,
   output logic [LOG_N-1:0] NTT_base_level,
   output logic [LOG_E-1:0] diff_logN,
   input  logic             NTT_working,
   output logic [LOG_N-1:0] pass_idx
`ifdef NTT_SEQ_PERF_EN
   ,
   output logic [31:0]      busy_cycles
`endif
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE     = 3'd1;
   localparam logic [2:0] WAIT_RISE = 3'd2;
   localparam logic [2:0] WAIT_FALL = 3'd3;
   localparam logic [2:0] NEXT      = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [FSIZE-1:0] p_q, p_d;
   logic [LOG_E-1:0] diff_q, diff_d;
   logic [LOG_E-1:0] levels_q, levels_d;
   logic [LOG_N-1:0] base_q, base_d;
   logic [LOG_N-1:0] idx_q, idx_d;
   logic [LOG_N-1:0] last_q, last_d;
   logic             err_q, err_d;

   logic             accept;
   logic             bad_req;
   logic [LOG_N-1:0] l_len;
   logic [LOG_N-1:0] n_passes;
   logic [LOG_N-1:0] rem;
   logic [LOG_N-1:0] first_lv;

   assign accept  = req_valid && (state_q == IDLE);
   assign bad_req = 32'(req_diff_logN) >= 32'(LOG_N);

   // Pass count and first-pass depth: the short pass goes first so later passes are full width.
   always_comb begin
      l_len    = LOG_N'(LOG_N) - LOG_N'(req_diff_logN);
      n_passes = (l_len + LOG_N'(LOG_E - 1)) / LOG_N'(LOG_E);
      rem      = l_len % LOG_N'(LOG_E);
      first_lv = (rem == '0) ? LOG_N'(LOG_E) : rem;
   end

   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      diff_d   = diff_q;
      levels_d = levels_q;
      base_d   = base_q;
      idx_d    = idx_q;
      last_d   = last_q;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bad_req) begin
                  err_d = 1'b1;
               end else begin
                  p_d      = req_p;
                  diff_d   = req_diff_logN;
                  levels_d = LOG_E'(first_lv);
                  base_d   = '0;
                  idx_d    = '0;
                  last_d   = n_passes - LOG_N'(1);
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE:     if (!NTT_working) state_d = WAIT_RISE;
         WAIT_RISE: if (NTT_working) state_d = WAIT_FALL;
         WAIT_FALL: if (!NTT_working) state_d = NEXT;
         NEXT: begin
            if (idx_q == last_q) begin
               state_d = IDLE;
            end else begin
               base_d   = base_q + LOG_N'(levels_q);
               levels_d = LOG_E'(LOG_E);
               idx_d    = idx_q + LOG_N'(1);
               state_d  = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         p_q      <= '0;
         diff_q   <= '0;
         levels_q <= '0;
         base_q   <= '0;
         idx_q    <= '0;
         last_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         p_q      <= p_d;
         diff_q   <= diff_d;
         levels_q <= levels_d;
         base_q   <= base_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

   assign req_ready      = (state_q == IDLE);
   assign start_NTT      = (state_q == ISSUE) && !NTT_working;
   assign job_done       = (state_q == NEXT) && (idx_q == last_q);
   assign job_err        = err_q;
   assign p              = p_q;
   assign diff_logN      = diff_q;
   assign NTT_levels     = levels_q;
   assign NTT_base_level = base_q;
   assign pass_idx       = idx_q;

`ifdef NTT_SEQ_PERF_EN
   logic [31:0] busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else if (accept && !bad_req) begin
         busy_q <= '0;
      end else if ((state_q != IDLE) && (busy_q != '1)) begin
         busy_q <= busy_q + 32'd1;
      end
   end

   assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Scoreboard bench for ntt_pass_sequencer: expected passes are queued by stimulus and
// popped by a monitor on every start_NTT / job_done / job_err.
module tb_ntt_pass_sequencer;
   localparam int LOG_N = 16;
   localparam int LOG_E = 3;
   localparam int FSIZE = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [FSIZE-1:0] req_p = '0;
   logic [LOG_E-1:0] req_diff_logN = '0;
   logic             job_done, job_err, start_NTT;
   logic [FSIZE-1:0] p;
   logic [LOG_E-1:0] NTT_levels, diff_logN;
   logic [LOG_N-1:0] NTT_base_level, pass_idx;
   logic             NTT_working;
   logic             ext_busy = 1'b0;
   logic             model_busy = 1'b0;
   assign NTT_working = ext_busy | model_busy;
`ifdef NTT_SEQ_PERF_EN
   logic [31:0]      busy_cycles;
`endif

   // Second instance with LOG_E=5 so diff=16 is representable.
   logic             req_valid_e = 1'b0;
   logic             req_ready_e;
   logic [4:0]       req_diff_e = '0;
   logic             job_done_e, job_err_e, start_NTT_e;
   logic [FSIZE-1:0] p_e;
   logic [4:0]       levels_e, diff_out_e;
   logic [LOG_N-1:0] base_e, pass_idx_e;
   logic             working_e = 1'b0;
`ifdef NTT_SEQ_PERF_EN
   logic [31:0]      busy_cycles_e;
`endif

   ntt_pass_sequencer #(.LOG_N(LOG_N), .LOG_E(LOG_E), .FSIZE(FSIZE)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_p(req_p),
      .req_diff_logN(req_diff_logN), .job_done(job_done), .job_err(job_err),
      .start_NTT(start_NTT), .p(p), .NTT_levels(NTT_levels), .NTT_base_level(NTT_base_level),
      .diff_logN(diff_logN), .NTT_working(NTT_working), .pass_idx(pass_idx)
`ifdef NTT_SEQ_PERF_EN
      , .busy_cycles(busy_cycles)
`endif
   );

   ntt_pass_sequencer #(.LOG_N(16), .LOG_E(5), .FSIZE(FSIZE)) dut_e (
      .clk(clk), .rst(rst), .req_valid(req_valid_e), .req_ready(req_ready_e),
      .req_p(64'h1234), .req_diff_logN(req_diff_e), .job_done(job_done_e),
      .job_err(job_err_e), .start_NTT(start_NTT_e), .p(p_e), .NTT_levels(levels_e),
      .NTT_base_level(base_e), .diff_logN(diff_out_e), .NTT_working(working_e),
      .pass_idx(pass_idx_e)
`ifdef NTT_SEQ_PERF_EN
      , .busy_cycles(busy_cycles_e)
`endif
   );

   typedef struct packed {
      logic [LOG_E-1:0] lv;
      logic [LOG_N-1:0] base;
      logic [LOG_N-1:0] idx;
      logic [FSIZE-1:0] pv;
      logic [LOG_E-1:0] diff;
   } pass_t;

   pass_t exp_q[$];
   int    done_q[$];
   int    err_q[$];
   int    checks = 0;
   int    errors = 0;
   int    busy_len = 3;
   logic  stab_en = 1'b1;
   pass_t cur;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // NTT controller model: busy for busy_len cycles, starting the cycle after start_NTT.
   initial begin
      forever begin
         @(negedge clk);
         if (start_NTT && !rst) begin
            @(posedge clk);
            #1 model_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 model_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (start_NTT) begin
            check("start_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               check("levels", 64'(NTT_levels), 64'(cur.lv));
               check("base", 64'(NTT_base_level), 64'(cur.base));
               check("pass_idx", 64'(pass_idx), 64'(cur.idx));
               check("p", p, cur.pv);
               check("diff", 64'(diff_logN), 64'(cur.diff));
            end
         end
         if (model_busy && stab_en) begin
            check("stable_levels", 64'(NTT_levels), 64'(cur.lv));
            check("stable_base", 64'(NTT_base_level), 64'(cur.base));
            check("stable_p", p, cur.pv);
         end
         if (job_done) begin
            check("done_expected", 64'(done_q.size() != 0), 64'd1);
            if (done_q.size() != 0) void'(done_q.pop_front());
            check("done_err_exclusive", 64'(job_err), 64'd0);
         end
         if (job_err) check("main_job_err", 64'(job_err), 64'd0);
         if (job_err_e) begin
            check("err_expected", 64'(err_q.size() != 0), 64'd1);
            if (err_q.size() != 0) void'(err_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pass(input int lv, input int base, input int idx, input logic [63:0] pv,
                            input int diff);
      pass_t e;
      e.lv   = LOG_E'(lv);
      e.base = LOG_N'(base);
      e.idx  = LOG_N'(idx);
      e.pv   = pv;
      e.diff = LOG_E'(diff);
      exp_q.push_back(e);
   endtask

   // Hand-computed pass tables for diff 0, 1 and 2.
   task automatic push_job(input int diff, input logic [63:0] pv);
      int lv0[6]   = '{1, 3, 3, 3, 3, 3};
      int base0[6] = '{0, 1, 4, 7, 10, 13};
      int base1[5] = '{0, 3, 6, 9, 12};
      int lv2[5]   = '{2, 3, 3, 3, 3};
      int base2[5] = '{0, 2, 5, 8, 11};
      if (diff == 0) for (int i = 0; i < 6; i++) push_pass(lv0[i], base0[i], i, pv, 0);
      if (diff == 1) for (int i = 0; i < 5; i++) push_pass(3, base1[i], i, pv, 1);
      if (diff == 2) for (int i = 0; i < 5; i++) push_pass(lv2[i], base2[i], i, pv, 2);
      done_q.push_back(1);
   endtask

   task automatic issue_req(input logic [63:0] pv, input int diff);
      req_valid     = 1'b1;
      req_p         = pv;
      req_diff_logN = LOG_E'(diff);
      tick();
      req_valid     = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done_seen"}, 64'(done_q.size()), 64'd0);
      check({name, "_passes_left"}, 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ready"}, 64'(req_ready), 64'd1);
      check({name, "_start"}, 64'(start_NTT), 64'd0);
      check({name, "_done"}, 64'(job_done), 64'd0);
      check({name, "_err"}, 64'(job_err), 64'd0);
      check({name, "_p"}, p, 64'd0);
      check({name, "_levels"}, 64'(NTT_levels), 64'd0);
      check({name, "_base"}, 64'(NTT_base_level), 64'd0);
      check({name, "_diff"}, 64'(diff_logN), 64'd0);
      check({name, "_idx"}, 64'(pass_idx), 64'd0);
`ifdef NTT_SEQ_PERF_EN
      check({name, "_busy_cycles"}, 64'(busy_cycles), 64'd0);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      int n;
      repeat (3) tick();
      check_reset_outputs("reset");

      // Deassert reset and request on the very next edge.
      rst = 1'b0;
      push_job(0, 64'hFFFF_FFFF_0000_0001);
      issue_req(64'hFFFF_FFFF_0000_0001, 0);
      check("accept_first_edge", 64'(req_ready), 64'd0);
      wait_done("diff0");

      // diff=1, with a request during the job that must be ignored.
      push_job(1, 64'h0000_0000_7FFF_E001);
      issue_req(64'h0000_0000_7FFF_E001, 1);
      repeat (5) tick();
      issue_req(64'hDEAD_BEEF_DEAD_BEEF, 2);
      wait_done("diff1");

      push_job(2, 64'h0FFF_FFFF_FFFF_FFC5);
      issue_req(64'h0FFF_FFFF_FFFF_FFC5, 2);
      wait_done("diff2");

      // Controller busy before the first pass: start must wait until it falls.
      ext_busy = 1'b1;
      push_job(1, 64'h0000_0001_0000_0001);
      issue_req(64'h0000_0001_0000_0001, 1);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("start_held_off", 64'(start_NTT), 64'd0);
         tick();
      end
      ext_busy = 1'b0;
      @(negedge clk);
      check("start_after_fall", 64'(start_NTT), 64'd1);
      wait_done("busy_pre");

      // Reset during the third pass while waiting for the controller to finish.
      busy_len = 6;
      push_job(0, 64'h0000_0000_0000_F001);
      issue_req(64'h0000_0000_0000_F001, 0);
      hits = 0;
      n    = 0;
      while (hits < 3 && n < 1000) begin
         @(negedge clk);
         #1;
         if (pass_idx == LOG_N'(2) && model_busy) hits++;
         n++;
      end
      check("reached_pass3_wait", 64'(hits), 64'd3);
      stab_en = 1'b0;
      #1 rst = 1'b1;
      #1 check_reset_outputs("midpass_reset");
      exp_q.delete();
      done_q.delete();
      n = 0;
      while (model_busy && n < 100) begin
         tick();
         n++;
      end
      rst = 1'b0;
      busy_len = 3;
      stab_en = 1'b1;
      push_job(0, 64'h0000_0000_0000_0011);
      issue_req(64'h0000_0000_0000_0011, 0);
      check("restart_accept", 64'(req_ready), 64'd0);
      wait_done("restart");

`ifdef NTT_SEQ_PERF_EN
      // Each pass: ISSUE 1 + WAIT_RISE 1 + WAIT_FALL 20 + NEXT 1 = 23 cycles, 6 passes.
      busy_len = 20;
      push_job(0, 64'h0000_0000_0000_0101);
      issue_req(64'h0000_0000_0000_0101, 0);
      check("busy_cleared_on_accept", 64'(busy_cycles <= 32'd1), 64'd1);
      wait_done("perf");
      repeat (2) tick();
      check("busy_cycles", 64'(busy_cycles), 64'd138);
      repeat (5) tick();
      check("busy_cycles_held", 64'(busy_cycles), 64'd138);
      busy_len = 3;
`endif

      // Out-of-range ring reduction on the LOG_E=5 instance.
      req_diff_e  = 5'd16;
      req_valid_e = 1'b1;
      err_q.push_back(1);
      @(negedge clk);
      check("err_ready_before", 64'(req_ready_e), 64'd1);
      tick();
      req_valid_e = 1'b0;
      @(negedge clk);
      check("err_pulse", 64'(job_err_e), 64'd1);
      check("err_no_start", 64'(start_NTT_e), 64'd0);
      check("err_ready_after", 64'(req_ready_e), 64'd1);
      check("err_no_done", 64'(job_done_e), 64'd0);
      tick();
      @(negedge clk);
      check("err_one_cycle", 64'(job_err_e), 64'd0);
      check("err_no_start_late", 64'(start_NTT_e), 64'd0);
      check("err_popped", 64'(err_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
